// File: rtl/cnn_pkg.sv
// Shared types for the convolution scan datapath: index/address widths and scan FSM encoding.
// No logic of its own; the address helper is pure combinational arithmetic.
// No backpressure; consumers decide when results are taken.
package cnn_pkg;

    localparam int IDX_W  = 4;
    localparam int ADDR_W = 8;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        MAC    = 3'd2,
        OUT    = 3'd3,
        FINISH = 3'd4
    } scan_state_t;

    // Row-major pixel address of tap (kr, kc) inside the window at (wi, wj).
    // Everything is kept in 8 bits; the image is limited to 256 pixels and
    // every dimension to 15 so nothing here can overflow.
    function automatic addr_t pix_addr_f(
        input idx_t  wi,
        input idx_t  wj,
        input idx_t  kr,
        input idx_t  kc,
        input addr_t cols
    );
        addr_t row;
        addr_t col;
        row = addr_t'(wi) + addr_t'(kr);
        col = addr_t'(wj) + addr_t'(kc);
        return addr_t'(row * cols) + col;
    endfunction

endpackage

// File: rtl/tap_counter.sv
// Filter tap walker: steps (k_r, k_c) row-major over a K_ROWS x K_COLS kernel.
// Zero latency on the wrap flag (decoded from the count flops); count updates one cycle after en.
// No backpressure; clr wins over en, and the count returns to (0,0) after the last tap.
module tap_counter
    import cnn_pkg::*;
#(
    parameter int K_ROWS = 2,
    parameter int K_COLS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output idx_t       k_r,
    output idx_t       k_c,
    output logic       last
);

    localparam idx_t KR_MAX = idx_t'(K_ROWS - 1);
    localparam idx_t KC_MAX = idx_t'(K_COLS - 1);

    idx_t k_r_q, k_r_d;
    idx_t k_c_q, k_c_d;
    logic last_tap;

    assign last_tap = (k_r_q == KR_MAX) && (k_c_q == KC_MAX);

    // Next tap: column first, row on column wrap, back to origin after the final tap.
    always_comb begin
        k_r_d = k_r_q;
        k_c_d = k_c_q;
        if (clr) begin
            k_r_d = '0;
            k_c_d = '0;
        end else if (en) begin
            if (k_c_q == KC_MAX) begin
                k_c_d = '0;
                k_r_d = last_tap ? '0 : k_r_q + idx_t'(1);
            end else begin
                k_c_d = k_c_q + idx_t'(1);
            end
        end
    end

    // Tap count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r_q <= '0;
            k_c_q <= '0;
        end else begin
            k_r_q <= k_r_d;
            k_c_q <= k_c_d;
        end
    end

    assign k_r  = k_r_q;
    assign k_c  = k_c_q;
    assign last = last_tap;

endmodule

// File: rtl/conv_scan_controller.sv
// Convolution scan sequencer: walks every valid window, clearing, accumulating K_ROWS*K_COLS taps, then presenting each result.
// Latency: first result 6 cycles after start (defaults), K_ROWS*K_COLS+2 cycles per window when out_ready stays high.
// Backpressure: OUT holds out_valid with a stable window index until out_ready; abort cancels from any active state.
module conv_scan_controller
    import cnn_pkg::*;
#(
    parameter int IMG_ROWS = 3,
    parameter int IMG_COLS = 5,
    parameter int K_ROWS   = 2,
    parameter int K_COLS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  win_i,
    output logic [IDX_W-1:0]  win_j,
    output logic [IDX_W-1:0]  k_r,
    output logic [IDX_W-1:0]  k_c,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              acc_clr,
    output logic              mac_en,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    // Dimensions are expected within 1..15 and IMG_ROWS*IMG_COLS <= 256 so
    // that the 4-bit indices and 8-bit address never wrap.
    localparam idx_t  WI_LAST = idx_t'(IMG_ROWS - K_ROWS);
    localparam idx_t  WJ_LAST = idx_t'(IMG_COLS - K_COLS);
    localparam addr_t COLS    = addr_t'(IMG_COLS);

    scan_state_t state_q, state_d;
    idx_t        win_i_q, win_i_d;
    idx_t        win_j_q, win_j_d;

    idx_t tap_r;
    idx_t tap_c;
    logic tap_last;
    logic tap_clr;
    logic tap_en;
    logic win_last;

    // Taps only advance in MAC; any other state (or an abort) parks them at
    // the origin so CLEAR always starts the next window from tap (0,0).
    assign tap_en  = (state_q == MAC);
    assign tap_clr = (state_q != MAC) || abort;

    tap_counter #(
        .K_ROWS (K_ROWS),
        .K_COLS (K_COLS)
    ) u_tap_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (tap_clr),
        .en    (tap_en),
        .k_r   (tap_r),
        .k_c   (tap_c),
        .last  (tap_last)
    );

    assign win_last = (win_i_q == WI_LAST) && (win_j_q == WJ_LAST);

    // Next state and window position; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        win_i_d = win_i_q;
        win_j_d = win_j_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    win_i_d = '0;
                    win_j_d = '0;
                end
            end
            CLEAR: begin
                state_d = MAC;
            end
            MAC: begin
                if (tap_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = win_last ? FINISH : CLEAR;
                    if (win_j_q == WJ_LAST) begin
                        win_j_d = '0;
                        win_i_d = win_i_q + idx_t'(1);
                    end else begin
                        win_j_d = win_j_q + idx_t'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Cancel leaves the window indices untouched: an aborted result is
        // never counted as handed off.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            win_i_d = win_i_q;
            win_j_d = win_j_q;
        end
    end

    // State and window registers; reset drops any scan in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_i_q <= '0;
            win_j_q <= '0;
        end else begin
            state_q <= state_d;
            win_i_q <= win_i_d;
            win_j_q <= win_j_d;
        end
    end

    // Outputs decode flops only, so nothing here depends on an input this cycle.
    assign win_i     = win_i_q;
    assign win_j     = win_j_q;
    assign k_r       = tap_r;
    assign k_c       = tap_c;
    assign pix_addr  = pix_addr_f(win_i_q, win_j_q, tap_r, tap_c, COLS);
    assign acc_clr   = (state_q == CLEAR);
    assign mac_en    = (state_q == MAC);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q == CLEAR) || (state_q == MAC) || (state_q == OUT);
    assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_conv_scan_controller.sv
// Self-checking bench for conv_scan_controller: window order, tap addresses and timing against a loop-nest model.
// Scans run with out_ready either held high or randomly stalled, plus directed abort/reset cases.
// Every wait on the DUT is bounded; a missed bound is a failed check.
module tb_conv_scan_controller;

    localparam int IR      = 3;
    localparam int IC      = 5;
    localparam int KR      = 2;
    localparam int KC      = 2;
    localparam int NWIN    = (IR - KR + 1) * (IC - KC + 1);
    localparam int WIN_CYC = KR * KC + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       out_ready;
    logic [3:0] win_i, win_j, k_r, k_c;
    logic [7:0] pix_addr;
    logic       acc_clr, mac_en, out_valid, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_win[$];
    logic [7:0] exp_addr[$];
    logic [7:0] got_win[$];
    logic [7:0] got_addr[$];
    logic [7:0] win12_addr[4] = '{8'd7, 8'd8, 8'd12, 8'd13};

    conv_scan_controller #(
        .IMG_ROWS (IR),
        .IMG_COLS (IC),
        .K_ROWS   (KR),
        .K_COLS   (KC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
        .win_i     (win_i),
        .win_j     (win_j),
        .k_r       (k_r),
        .k_c       (k_c),
        .pix_addr  (pix_addr),
        .acc_clr   (acc_clr),
        .mac_en    (mac_en),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] out_vec();
        return {3'b000, win_i, win_j, k_r, k_c, pix_addr, acc_clr, mac_en, out_valid, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: windows visited row-major, each window's taps row-major.
    task automatic build_model();
        for (int i = 0; i <= IR - KR; i++) begin
            for (int j = 0; j <= IC - KC; j++) begin
                exp_win.push_back(8'(i * 16 + j));
                for (int r = 0; r < KR; r++)
                    for (int c = 0; c < KC; c++)
                        exp_addr.push_back(8'((i + r) * IC + j + c));
            end
        end
    endtask

    task automatic wait_until(input bit want_mac, input int wj, input string tag);
        int n;
        n = 0;
        while (!((want_mac ? mac_en : out_valid) && (int'(win_j) == wj)) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'((want_mac ? mac_en : out_valid) && (int'(win_j) == wj)), 1);
    endtask

    // One complete scan from start to done, recording what the DUT emits.
    task automatic run_scan(input bit rnd_ready, input bit poke_start, input string tag);
        int         cyc, stalls, first_ov, n_clr;
        bit         seen_done, prev_stall;
        logic [7:0] prev_win;
        got_win.delete();
        got_addr.delete();
        stalls = 0; first_ov = -1; n_clr = 0; seen_done = 0; prev_stall = 0; prev_win = '0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            start     = poke_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (mac_en) got_addr.push_back(pix_addr);
            if (acc_clr) n_clr++;
            if (prev_stall) begin
                check({tag, "_stall_valid"}, 32'(out_valid), 1);
                check({tag, "_stall_win"}, 32'({win_i, win_j}), 32'(prev_win));
            end
            prev_stall = 0;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (out_ready) got_win.push_back({win_i, win_j});
                else begin
                    stalls++;
                    prev_stall = 1;
                    prev_win   = {win_i, win_j};
                end
            end
            if (done) begin
                seen_done = 1;
                start = 1'b0;
                break;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check({tag, "_done_seen"}, 32'(seen_done), 1);
        check({tag, "_done_cycle"}, cyc, NWIN * WIN_CYC + 1 + stalls);
        check({tag, "_first_out"}, first_ov, WIN_CYC);
        check({tag, "_n_clear"}, n_clr, NWIN);
        check({tag, "_n_win"}, got_win.size(), exp_win.size());
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++)
            check($sformatf("%s_win%0d", tag, k), 32'(got_win[k]), 32'(exp_win[k]));
        check({tag, "_n_addr"}, got_addr.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++)
            check($sformatf("%s_addr%0d", tag, k), 32'(got_addr[k]), 32'(exp_addr[k]));
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        build_model();
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_after_reset", out_vec(), 0);

        // Nominal scan, then the tap addresses of window (1,2).
        run_scan(1'b0, 1'b0, "nom");
        for (int t = 0; t < 4; t++)
            if (got_addr.size() >= 28)
                check($sformatf("win12_addr%0d", t), 32'(got_addr[24 + t]), 32'(win12_addr[t]));

        // First OUT held off for 5 cycles.
        start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        wait_until(1'b0, 0, "stall");
        for (int s = 0; s < 5; s++) begin
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_win_j", 32'(win_j), 0);
            tick();
        end
        out_ready = 1'b1;
        check("stall_still_valid", 32'(out_valid), 1);
        tick();
        check("stall_win_j_adv", 32'(win_j), 1);
        check("stall_next_clear", 32'(acc_clr), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("stall_abort_busy", 32'(busy), 0);

        // Abort in the middle of window (0,2) accumulation.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(1'b1, 2, "abort_mac");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_mac_busy", 32'(busy), 0);
        check("abort_mac_en", 32'(mac_en), 0);
        for (int s = 0; s < 6; s++) begin
            check("abort_mac_no_done", 32'(done), 0);
            tick();
        end
        run_scan(1'b0, 1'b0, "after_abort");

        // Abort together with a handshake in OUT of window (0,1).
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(1'b0, 1, "abort_out");
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_out_busy", 32'(busy), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_out_win", 32'({win_i, win_j}), 32'h01);
        for (int s = 0; s < 4; s++) begin
            check("abort_out_no_done", 32'(done), 0);
            tick();
        end

        // Randomly stalled scans with start poked while busy.
        for (int r = 0; r < 3; r++)
            run_scan(1'b1, 1'b1, $sformatf("rnd%0d", r));

        // Reset asserted between edges while window (0,1) is in OUT.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(1'b0, 1, "rst_out");
        #2 reset = 1'b1;
        #1 check("rst_async_outputs", out_vec(), 0);
        tick();
        check("rst_held_outputs", out_vec(), 0);
        reset = 1'b0;
        tick();
        check("rst_release_idle", out_vec(), 0);
        run_scan(1'b0, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
